game_board_ctrl: RTL and testbench

GAME_BOARD_CTRL -- requirements
Module: game_board_ctrl

---
 rtl/game_board_ctrl.sv | 246 ++++++++++++++++++++++++
 tb/tb_game_board_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_board_ctrl.sv
// game_board_ctrl: N x N tic-tac-toe style board controller.
// Accepts moves over a valid/ready handshake, reports move errors, and runs
// a four-cycle win check (one axis per cycle) through the placed cell.
// Also runs a free-running row-major cell scanner.
// Optional feature: define GAME_UNDO_EN to add a one-level undo port.
module game_board_ctrl #(
    parameter int N = 3,
    parameter int K = 3,
    localparam int IW = ($clog2(N) > 1) ? $clog2(N) : 1,
    localparam int CW = $clog2(N * N + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          mv_valid,
    output logic          mv_ready,
    input  logic [1:0]    mv_mark,
    input  logic [IW-1:0] mv_row,
    input  logic [IW-1:0] mv_col,
`ifdef GAME_UNDO_EN
    input  logic          undo,
`endif
    output logic [2:0]    err_code,
    output logic [1:0]    turn,
    output logic [1:0]    win,
    output logic [CW-1:0] move_cnt,
    output logic [IW-1:0] scan_row,
    output logic [IW-1:0] scan_col,
    output logic [1:0]    scan_mark
);

    localparam int CELLS = N * N;
    localparam int AW    = $clog2(CELLS);

    typedef enum logic [1:0] {
        PLAY  = 2'b00,
        CHECK = 2'b01,
        OVER  = 2'b10
    } state_t;

    state_t        state_r;
    logic          ready_r;
    logic [2:0]    err_r;
    logic [1:0]    turn_r;
    logic [1:0]    win_r;
    logic [CW-1:0] cnt_r;
    logic [1:0]    board_r [CELLS];
    logic [IW-1:0] last_row_r;
    logic [IW-1:0] last_col_r;
    logic [1:0]    last_mark_r;
    logic [1:0]    axis_r;
    logic          hit_r;
    logic [IW-1:0] scan_row_r;
    logic [IW-1:0] scan_col_r;
`ifdef GAME_UNDO_EN
    logic          armed_r;
`endif

    logic          hs_s;
    logic          parse_s;
    logic [2:0]    err_s;
    logic          axis_hit_s;
    int            dr_s;
    int            dc_s;
    int            fwd_s;
    int            bwd_s;
    logic          fwd_go_s;
    logic          bwd_go_s;

    // Flatten a (row, col) pair into a board array index.
    function automatic logic [AW-1:0] cell_index(input int r, input int c);
        return AW'(r * N + c);
    endfunction

    // Cell contents with off-board coordinates reading as empty, so lines never wrap.
    function automatic logic [1:0] cell_at(input int r, input int c);
        logic [1:0] v;
        if ((r >= 0) && (r < N) && (c >= 0) && (c < N)) begin
            v = board_r[cell_index(r, c)];
        end else begin
            v = 2'b00;
        end
        return v;
    endfunction

    assign hs_s      = mv_valid & ready_r;
    assign mv_ready  = ready_r;
    assign err_code  = err_r;
    assign turn      = turn_r;
    assign win       = win_r;
    assign move_cnt  = cnt_r;
    assign scan_row  = scan_row_r;
    assign scan_col  = scan_col_r;
    assign scan_mark = board_r[cell_index(int'(scan_row_r), int'(scan_col_r))];

    // Classify the offered move with parse > gameover > turn > occupied priority.
    always_comb begin
        parse_s = (int'(mv_row) >= N) || (int'(mv_col) >= N) ||
                  (mv_mark == 2'b00) || (mv_mark == 2'b11);
        if (parse_s) begin
            err_s = 3'd1;
        end else if (state_r == OVER) begin
            err_s = 3'd2;
        end else if (mv_mark != turn_r) begin
            err_s = 3'd3;
        end else if (cell_at(int'(mv_row), int'(mv_col)) != 2'b00) begin
            err_s = 3'd4;
        end else begin
            err_s = 3'd0;
        end
    end

    // Count the run of matching marks through the placed cell along the current axis.
    always_comb begin
        dr_s = 0;
        dc_s = 0;
        case (axis_r)
            2'd0: begin dr_s = 0; dc_s = 1;  end
            2'd1: begin dr_s = 1; dc_s = 0;  end
            2'd2: begin dr_s = 1; dc_s = 1;  end
            2'd3: begin dr_s = 1; dc_s = -1; end
            default: begin dr_s = 0; dc_s = 1; end
        endcase
        fwd_s    = 0;
        bwd_s    = 0;
        fwd_go_s = 1'b1;
        bwd_go_s = 1'b1;
        for (int i = 1; i < N; i++) begin
            if (fwd_go_s && (cell_at(int'(last_row_r) + i * dr_s,
                                     int'(last_col_r) + i * dc_s) == last_mark_r)) begin
                fwd_s = fwd_s + 1;
            end else begin
                fwd_go_s = 1'b0;
            end
            if (bwd_go_s && (cell_at(int'(last_row_r) - i * dr_s,
                                     int'(last_col_r) - i * dc_s) == last_mark_r)) begin
                bwd_s = bwd_s + 1;
            end else begin
                bwd_go_s = 1'b0;
            end
        end
        axis_hit_s = ((fwd_s + bwd_s + 1) >= K);
    end

    // Game FSM, board storage, error reporting and the free-running scanner.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= PLAY;
            ready_r     <= 1'b1;
            err_r       <= 3'd0;
            turn_r      <= 2'b10;
            win_r       <= 2'b00;
            cnt_r       <= {CW{1'b0}};
            last_row_r  <= {IW{1'b0}};
            last_col_r  <= {IW{1'b0}};
            last_mark_r <= 2'b00;
            axis_r      <= 2'd0;
            hit_r       <= 1'b0;
            scan_row_r  <= {IW{1'b0}};
            scan_col_r  <= {IW{1'b0}};
`ifdef GAME_UNDO_EN
            armed_r     <= 1'b0;
`endif
            for (int i = 0; i < CELLS; i++) begin
                board_r[AW'(i)] <= 2'b00;
            end
        end else begin
            err_r <= 3'd0;

            if (scan_col_r == IW'(N - 1)) begin
                scan_col_r <= {IW{1'b0}};
                if (scan_row_r == IW'(N - 1)) begin
                    scan_row_r <= {IW{1'b0}};
                end else begin
                    scan_row_r <= scan_row_r + IW'(1);
                end
            end else begin
                scan_col_r <= scan_col_r + IW'(1);
            end

            case (state_r)
                PLAY: begin
                    if (hs_s) begin
                        if (err_s != 3'd0) begin
                            err_r <= err_s;
                        end else begin
                            board_r[cell_index(int'(mv_row), int'(mv_col))] <= mv_mark;
                            cnt_r       <= cnt_r + CW'(1);
                            last_row_r  <= mv_row;
                            last_col_r  <= mv_col;
                            last_mark_r <= mv_mark;
                            axis_r      <= 2'd0;
                            hit_r       <= 1'b0;
                            ready_r     <= 1'b0;
                            state_r     <= CHECK;
`ifdef GAME_UNDO_EN
                            armed_r     <= 1'b1;
`endif
                        end
`ifdef GAME_UNDO_EN
                    end else if (undo && armed_r && (cnt_r != {CW{1'b0}})) begin
                        board_r[cell_index(int'(last_row_r), int'(last_col_r))] <= 2'b00;
                        cnt_r   <= cnt_r - CW'(1);
                        turn_r  <= {turn_r[0], turn_r[1]};
                        armed_r <= 1'b0;
`endif
                    end else begin
                        state_r <= PLAY;
                    end
                end
                CHECK: begin
                    axis_r <= axis_r + 2'd1;
                    hit_r  <= hit_r | axis_hit_s;
                    if (axis_r == 2'd3) begin
                        ready_r <= 1'b1;
                        if (hit_r | axis_hit_s) begin
                            win_r   <= last_mark_r;
                            turn_r  <= 2'b00;
                            state_r <= OVER;
                        end else if (cnt_r == CW'(CELLS)) begin
                            win_r   <= 2'b11;
                            turn_r  <= 2'b00;
                            state_r <= OVER;
                        end else begin
                            turn_r  <= {turn_r[0], turn_r[1]};
                            state_r <= PLAY;
                        end
                    end else begin
                        state_r <= CHECK;
                    end
                end
                OVER: begin
                    if (hs_s) begin
                        err_r <= err_s;
                    end else begin
                        state_r <= OVER;
                    end
                end
                default: begin
                    state_r <= PLAY;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_board_ctrl.sv
// Directed bench for game_board_ctrl: one 3x3 (K=3) and one 5x5 (K=4) instance.
// Expected error codes are queued when a move is driven and popped after the edge.
module tb_game_board_ctrl;

    logic       clk = 1'b0;
    int         checks = 0;
    int         errors = 0;
    logic [2:0] err_q[$];
    logic [1:0] model3 [9];
    int         last_idx = 0;

    logic       reset3, v3, ready3;
    logic [1:0] m3, r3, c3, turn3, win3, srow3, scol3, smark3;
    logic [2:0] err3;
    logic [3:0] cnt3;

    logic       reset5, v5, ready5;
    logic [1:0] m5, turn5, win5, smark5;
    logic [2:0] r5, c5, err5, srow5, scol5;
    logic [4:0] cnt5;
`ifdef GAME_UNDO_EN
    logic       undo3 = 1'b0;
    logic       undo5 = 1'b0;
`endif

    always #5 clk = ~clk;

    game_board_ctrl #(.N(3), .K(3)) dut3 (
        .clk(clk), .reset(reset3), .mv_valid(v3), .mv_ready(ready3),
        .mv_mark(m3), .mv_row(r3), .mv_col(c3),
`ifdef GAME_UNDO_EN
        .undo(undo3),
`endif
        .err_code(err3), .turn(turn3), .win(win3), .move_cnt(cnt3),
        .scan_row(srow3), .scan_col(scol3), .scan_mark(smark3)
    );

    game_board_ctrl #(.N(5), .K(4)) dut5 (
        .clk(clk), .reset(reset5), .mv_valid(v5), .mv_ready(ready5),
        .mv_mark(m5), .mv_row(r5), .mv_col(c5),
`ifdef GAME_UNDO_EN
        .undo(undo5),
`endif
        .err_code(err5), .turn(turn5), .win(win5), .move_cnt(cnt5),
        .scan_row(srow5), .scan_col(scol5), .scan_mark(smark5)
    );

    function automatic logic [31:0] get_err(input int sel);
        return (sel == 0) ? 32'(err3) : 32'(err5);
    endfunction
    function automatic logic [31:0] get_turn(input int sel);
        return (sel == 0) ? 32'(turn3) : 32'(turn5);
    endfunction
    function automatic logic [31:0] get_win(input int sel);
        return (sel == 0) ? 32'(win3) : 32'(win5);
    endfunction
    function automatic logic [31:0] get_cnt(input int sel);
        return (sel == 0) ? 32'(cnt3) : 32'(cnt5);
    endfunction
    function automatic logic [31:0] get_ready(input int sel);
        return (sel == 0) ? 32'(ready3) : 32'(ready5);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input int sel, input string tag, input logic [1:0] t,
                             input logic [1:0] w, input int cnt);
        chk({tag, "_turn"}, get_turn(sel), 32'(t));
        chk({tag, "_win"},  get_win(sel),  32'(w));
        chk({tag, "_cnt"},  get_cnt(sel),  32'(cnt));
    endtask

    task automatic drive(input int sel, input logic v, input logic [1:0] mark,
                         input int row, input int col);
        if (sel == 0) begin
            v3 = v; m3 = mark; r3 = row[1:0]; c3 = col[1:0];
        end else begin
            v5 = v; m5 = mark; r5 = row[2:0]; c5 = col[2:0];
        end
    endtask

    task automatic do_reset(input int sel);
        @(negedge clk);
        if (sel == 0) reset3 = 1'b1; else reset5 = 1'b1;
        drive(sel, 1'b0, 2'b00, 0, 0);
        @(posedge clk); #1;
        chk("rst_err", get_err(sel), 32'd0);
        chk_state(sel, "rst", 2'b10, 2'b00, 0);
        chk("rst_scan_row", (sel == 0) ? 32'(srow3) : 32'(srow5), 32'd0);
        chk("rst_scan_col", (sel == 0) ? 32'(scol3) : 32'(scol5), 32'd0);
        chk("rst_scan_mark", (sel == 0) ? 32'(smark3) : 32'(smark5), 32'd0);
        @(negedge clk);
        if (sel == 0) reset3 = 1'b0; else reset5 = 1'b0;
        chk("rst_ready", get_ready(sel), 32'd1);
        if (sel == 0) begin
            for (int i = 0; i < 9; i++) model3[i] = 2'b00;
        end
    endtask

    // One handshake; for accepted moves also waits out the four CHECK cycles.
    task automatic move(input int sel, input logic [1:0] mark, input int row,
                        input int col, input logic [2:0] exp_err, input bit hold);
        int n;
        @(negedge clk);
        drive(sel, 1'b1, mark, row, col);
        err_q.push_back(exp_err);
        n = 0;
        while ((get_ready(sel) != 32'd1) && (n < 50)) begin
            @(negedge clk);
            n++;
        end
        chk("hs_ready", get_ready(sel), 32'd1);
        @(posedge clk); #1;
        if (!hold) drive(sel, 1'b0, mark, row, col);
        chk("err_code", get_err(sel), 32'(err_q.pop_front()));
        if (exp_err != 3'd0) begin
            @(posedge clk); #1;
            chk("err_clear", get_err(sel), 32'd0);
        end else begin
            if (sel == 0) begin
                last_idx = row * 3 + col;
                model3[last_idx] = mark;
            end
            chk("ready_in_check", get_ready(sel), 32'd0);
            for (int i = 1; i <= 3; i++) begin
                @(posedge clk); #1;
                if (hold) chk("hold_err", get_err(sel), 32'd0);
            end
            chk("win_before_e4", get_win(sel), 32'd0);
            @(posedge clk); #1;
            if (hold) begin
                chk("hold_err_e4", get_err(sel), 32'd0);
                drive(sel, 1'b0, mark, row, col);
            end
        end
    endtask

    task automatic scan_cell(input int row, input int col, input logic [1:0] exp);
        int n;
        n = 0;
        while (!((int'(srow3) == row) && (int'(scol3) == col)) && (n < 20)) begin
            @(posedge clk); #1;
            n++;
        end
        chk("scan_sync", 32'(n < 20), 32'd1);
        chk("scan_cell", 32'(smark3), 32'(exp));
    endtask

    task automatic scan_sweep();
        scan_cell(0, 0, model3[0]);
        for (int k = 0; k < 9; k++) begin
            chk("sweep_row", 32'(srow3), 32'(k / 3));
            chk("sweep_col", 32'(scol3), 32'(k % 3));
            chk("sweep_mark", 32'(smark3), 32'(model3[k]));
            @(posedge clk); #1;
        end
        chk("sweep_wrap", 32'({srow3, scol3}), 32'd0);
    endtask

`ifdef GAME_UNDO_EN
    task automatic do_undo(input bit honoured);
        @(negedge clk);
        undo3 = 1'b1;
        @(posedge clk); #1;
        undo3 = 1'b0;
        if (honoured) model3[last_idx] = 2'b00;
    endtask
`endif

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset3 = 1'b1; reset5 = 1'b1;
        drive(0, 1'b0, 2'b00, 0, 0);
        drive(1, 1'b0, 2'b00, 0, 0);
        do_reset(0);
        do_reset(1);

        // Error priority cases on a fresh board.
        move(0, 2'b01, 0, 0, 3'd3, 1'b0);
        move(0, 2'b10, 3, 0, 3'd1, 1'b0);
        move(0, 2'b00, 1, 1, 3'd1, 1'b0);
        move(0, 2'b10, 0, 3, 3'd1, 1'b0);
        chk_state(0, "after_rejects", 2'b10, 2'b00, 0);

        // X wins along row 0.
        move(0, 2'b10, 0, 0, 3'd0, 1'b0);
        chk_state(0, "x1", 2'b01, 2'b00, 1);
        move(0, 2'b01, 1, 0, 3'd0, 1'b0);
        chk_state(0, "o1", 2'b10, 2'b00, 2);
        move(0, 2'b10, 0, 1, 3'd0, 1'b0);
        move(0, 2'b01, 1, 1, 3'd0, 1'b0);
        move(0, 2'b10, 0, 2, 3'd0, 1'b0);
        chk_state(0, "xwin", 2'b00, 2'b10, 5);
        chk("over_ready", get_ready(0), 32'd1);
        move(0, 2'b01, 2, 2, 3'd2, 1'b0);
        move(0, 2'b11, 2, 2, 3'd1, 1'b0);
        chk_state(0, "over_hold", 2'b00, 2'b10, 5);
        scan_sweep();

        // Occupied cell, then a full-board tie.
        do_reset(0);
        move(0, 2'b10, 0, 0, 3'd0, 1'b0);
        move(0, 2'b01, 0, 0, 3'd4, 1'b0);
        chk_state(0, "occupied", 2'b01, 2'b00, 1);
        move(0, 2'b01, 0, 1, 3'd0, 1'b0);
        move(0, 2'b10, 0, 2, 3'd0, 1'b0);
        move(0, 2'b01, 1, 1, 3'd0, 1'b1);
        move(0, 2'b10, 1, 0, 3'd0, 1'b0);
        move(0, 2'b01, 1, 2, 3'd0, 1'b0);
        move(0, 2'b10, 2, 1, 3'd0, 1'b0);
        chk_state(0, "pre_tie", 2'b01, 2'b00, 7);
        move(0, 2'b01, 2, 0, 3'd0, 1'b0);
        move(0, 2'b10, 2, 2, 3'd0, 1'b0);
        chk_state(0, "tie", 2'b00, 2'b11, 9);
        scan_sweep();

        // 5x5, K=4: anti-diagonal win.
        move(1, 2'b10, 0, 4, 3'd0, 1'b0);
        move(1, 2'b01, 0, 0, 3'd0, 1'b0);
        move(1, 2'b10, 1, 3, 3'd0, 1'b0);
        move(1, 2'b01, 1, 0, 3'd0, 1'b0);
        move(1, 2'b10, 2, 2, 3'd0, 1'b0);
        move(1, 2'b01, 0, 1, 3'd0, 1'b0);
        chk_state(1, "anti_pre", 2'b10, 2'b00, 6);
        move(1, 2'b10, 3, 1, 3'd0, 1'b0);
        chk_state(1, "anti_win", 2'b00, 2'b10, 7);

        // 5x5: three in row 4 plus a row-major-adjacent X at (3,4) is not a line.
        do_reset(1);
        move(1, 2'b10, 3, 4, 3'd0, 1'b0);
        move(1, 2'b01, 0, 0, 3'd0, 1'b0);
        move(1, 2'b10, 4, 0, 3'd0, 1'b0);
        move(1, 2'b01, 0, 2, 3'd0, 1'b0);
        move(1, 2'b10, 4, 1, 3'd0, 1'b0);
        move(1, 2'b01, 2, 4, 3'd0, 1'b0);
        move(1, 2'b10, 4, 2, 3'd0, 1'b0);
        chk_state(1, "no_wrap", 2'b01, 2'b00, 7);
        move(1, 2'b01, 4, 3, 3'd0, 1'b0);
        chk_state(1, "no_wrap_o", 2'b10, 2'b00, 8);

`ifdef GAME_UNDO_EN
        do_reset(0);
        move(0, 2'b10, 1, 1, 3'd0, 1'b0);
        chk_state(0, "pre_undo", 2'b01, 2'b00, 1);
        do_undo(1'b1);
        chk_state(0, "undo1", 2'b10, 2'b00, 0);
        scan_cell(1, 1, 2'b00);
        do_undo(1'b0);
        chk_state(0, "undo2", 2'b10, 2'b00, 0);
        move(0, 2'b10, 2, 2, 3'd0, 1'b0);
        move(0, 2'b01, 0, 0, 3'd0, 1'b0);
        do_undo(1'b1);
        chk_state(0, "undo3", 2'b01, 2'b00, 1);
        do_undo(1'b0);
        chk_state(0, "undo4", 2'b01, 2'b00, 1);
        scan_cell(2, 2, 2'b10);
        scan_cell(0, 0, 2'b00);
`endif

        // Reset while in CHECK aborts the pending win check.
        do_reset(0);
        move(0, 2'b10, 0, 0, 3'd0, 1'b0);
        move(0, 2'b01, 1, 0, 3'd0, 1'b0);
        move(0, 2'b10, 0, 1, 3'd0, 1'b0);
        move(0, 2'b01, 1, 1, 3'd0, 1'b0);
        @(negedge clk);
        drive(0, 1'b1, 2'b10, 0, 2);
        @(posedge clk); #1;
        drive(0, 1'b0, 2'b10, 0, 2);
        chk("abort_in_check", get_ready(0), 32'd0);
        @(negedge clk);
        reset3 = 1'b1;
        @(posedge clk); #1;
        chk_state(0, "abort_rst", 2'b10, 2'b00, 0);
        chk("abort_ready", get_ready(0), 32'd1);
        chk("abort_err", get_err(0), 32'd0);
        @(negedge clk);
        reset3 = 1'b0;
        for (int i = 0; i < 9; i++) model3[i] = 2'b00;
        repeat (5) @(posedge clk);
        #1;
        chk_state(0, "abort_after", 2'b10, 2'b00, 0);
        scan_cell(0, 2, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
